fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 101 ++++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit : instruction fetch with one-entry IF buffer and redirect drain |
// | Revision   : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_valid,
  output logic        ifid_enable,
  output logic        ifid_flush
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic        r_busy;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;
  logic        w_buf_free;
  logic        w_ack;
  logic [31:0] w_redirect_tgt;

  assign if_pc          = r_if_pc;
  assign if_instr       = r_if_instr;
  assign if_valid       = r_if_valid;
  assign ifid_flush     = redirect;
  assign ifid_enable    = r_if_valid & ~stall & ~redirect;
  assign w_buf_free     = ~r_if_valid | ifid_enable;
  // An outstanding request (including a drain) holds the bus until acked.
  assign imem_req       = ~rst & (r_busy | ((r_state == ST_RUN) & w_buf_free));
  assign imem_addr      = r_busy ? r_req_addr : r_pc;
  assign w_ack          = imem_req & imem_ack;
  assign w_redirect_tgt = {redirect_pc[31:2], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = (imem_req & ~imem_ack) ? ST_DRAIN : ST_RUN;
    end else if ((r_state == ST_DRAIN) && w_ack) begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_busy     <= 1'b0;
      r_if_pc    <= 32'h0;
      r_if_instr <= 32'h0;
      r_if_valid <= 1'b0;
    end else begin
      if (imem_req) begin
        r_req_addr <= imem_addr;
      end
      r_busy <= imem_req & ~imem_ack;

      // Redirect wins over everything; data acked in DRAIN is dropped.
      if (redirect) begin
        r_pc       <= w_redirect_tgt;
        r_if_valid <= 1'b0;
      end else if ((r_state == ST_RUN) && w_ack) begin
        r_if_pc    <= imem_addr;
        r_if_instr <= imem_rdata;
        r_if_valid <= 1'b1;
        r_pc       <= r_pc + 32'd4;
      end else if (ifid_enable) begin
        r_if_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit : directed scoreboard bench for fetch_unit                   |
// | Revision      : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        ifid_enable;
  logic        ifid_flush;

  int total = 0;
  int bad   = 0;
  logic [63:0] q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_valid    (if_valid),
    .ifid_enable (ifid_enable),
    .ifid_flush  (ifid_flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check outputs, update the scoreboard, advance.
  task automatic step(input logic s, input logic r, input logic [31:0] rp,
                      input logic a, input logic er, input logic [31:0] ea,
                      input logic ee, input logic dv);
    logic [63:0] e;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    imem_ack    = a;
    imem_rdata  = a ? instr_of(imem_addr) : 32'h0;
    #1;
    chk("imem_req", {31'h0, imem_req}, {31'h0, er});
    if (er) chk("imem_addr", imem_addr, ea);
    chk("ifid_flush", {31'h0, ifid_flush}, {31'h0, r});
    chk("ifid_enable", {31'h0, ifid_enable}, {31'h0, ee});
    if (ee) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL scoreboard: observed=consume expected=empty buffer");
      end else begin
        e = q.pop_front();
        chk("if_pc", if_pc, e[63:32]);
        chk("if_instr", if_instr, e[31:0]);
      end
    end
    if (r) q.delete();
    if (dv) q.push_back({ea, instr_of(ea)});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    #3 rst = 1'b1;
    #1;
    chk("rst_if_valid", {31'h0, if_valid}, 32'h0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_ifid_enable", {31'h0, ifid_enable}, 32'h0);
    redirect = 1'b1;
    #1;
    chk("rst_ifid_flush", {31'h0, ifid_flush}, 32'h1);
    redirect = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // zero-wait streaming from reset
    step(0, 0, 0, 1, 1, 32'h0, 0, 1);
    step(0, 0, 0, 1, 1, 32'h4, 1, 1);
    step(0, 0, 0, 1, 1, 32'h8, 1, 1);

    // stall with a full buffer
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 32'h0, 0, 0);
    chk("stall_if_pc", if_pc, 32'h8);
    chk("stall_if_instr", if_instr, instr_of(32'h8));
    step(0, 0, 0, 0, 1, 32'hC, 1, 0);
    step(0, 0, 0, 1, 1, 32'hC, 0, 1);

    // three-cycle memory latency at 0x10
    step(0, 0, 0, 0, 1, 32'h10, 1, 0);
    step(0, 0, 0, 0, 1, 32'h10, 0, 0);
    step(0, 0, 0, 1, 1, 32'h10, 0, 1);
    chk("lat_if_pc", if_pc, 32'h10);
    chk("lat_if_valid", {31'h0, if_valid}, 32'h1);

    // redirect with a full buffer: no request, ack ignored
    step(0, 1, 32'h20, 1, 0, 32'h0, 0, 0);

    // redirect with request outstanding -> drain, then fetch target
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    step(0, 1, 32'h103, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 0, 1, 32'h20, 0, 0);
    step(0, 0, 0, 1, 1, 32'h20, 0, 0);
    chk("drain_if_valid", {31'h0, if_valid}, 32'h0);
    step(0, 0, 0, 1, 1, 32'h100, 0, 1);

    // redirect and stall together with a live buffer
    step(1, 1, 32'h200, 0, 0, 32'h0, 0, 0);
    chk("rs_if_valid", {31'h0, if_valid}, 32'h0);

    // redirect during drain takes the newest target
    step(0, 0, 0, 0, 1, 32'h200, 0, 0);
    step(0, 1, 32'h300, 0, 1, 32'h200, 0, 0);
    step(0, 1, 32'h404, 0, 1, 32'h200, 0, 0);
    step(0, 0, 0, 1, 1, 32'h200, 0, 0);
    step(0, 0, 0, 1, 1, 32'h404, 0, 1);

    // wrap from the top of the address space
    step(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 1, 1, 32'h0000_0000, 1, 1);
    step(0, 0, 0, 0, 1, 32'h0000_0004, 1, 0);

    // reset while the request at 0x4 is outstanding
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_if_valid", {31'h0, if_valid}, 32'h0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(0, 0, 0, 1, 1, 32'h0, 0, 1);

    // ack without a request must not disturb the buffer
    step(1, 0, 0, 1, 0, 32'h0, 0, 0);
    step(0, 0, 0, 1, 1, 32'h4, 1, 1);
    step(0, 0, 0, 0, 1, 32'h8, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
